tblink_rpc_invoke_responder: RTL and testbench

- HDL-side responder for TBLink RPC invoke traffic.
- Accepts framed invoke requests on a byte stream, decodes method id, call id and parameters, and presents the call to local user logic over a valid/ready call port.
- Waits for the user's return value, then serializes a response frame back on the outbound byte stream.
- It is the hardware end that services invokes issued by the HVL endpoint.

---
 rtl/tblink_rpc_invoke_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_tblink_rpc_invoke_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tblink_rpc_invoke_responder.sv
// TBLink RPC invoke responder: decodes framed invoke requests, presents them on a call port, serializes responses.
// Optional response timeout enabled by defining TBLINK_RPC_RESP_TIMEOUT_EN.
module tblink_rpc_invoke_responder #(
  parameter int NUM_METHODS    = 16,
  parameter int MAX_PARAMS     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [7:0]                rx_dat,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [7:0]                tx_dat,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      call_valid,
  input  logic                      call_ready,
  output logic [7:0]                call_method,
  output logic [7:0]                call_id,
  output logic [3:0]                call_nparams,
  output logic [32*MAX_PARAMS-1:0]  call_params,
  input  logic                      rsp_valid,
  output logic                      rsp_ready,
  input  logic [31:0]               rsp_retval,
  output logic [15:0]               err_count
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HDR_MID  = 4'd1,
    ST_HDR_CID  = 4'd2,
    ST_HDR_NP   = 4'd3,
    ST_PARAMS   = 4'd4,
    ST_DRAIN    = 4'd5,
    ST_CALL     = 4'd6,
    ST_WAIT_RSP = 4'd7,
    ST_ERR_TX   = 4'd8,
    ST_TX       = 4'd9
  } state_t;

  localparam logic [7:0]  SYNC_REQ       = 8'hA5;
  localparam logic [7:0]  SYNC_RSP       = 8'h5A;
  localparam logic [7:0]  STATUS_OK      = 8'd0;
  localparam logic [7:0]  STATUS_BAD_MID = 8'd1;
  localparam logic [7:0]  STATUS_TOO_MANY = 8'd2;
  localparam logic [7:0]  STATUS_TIMEOUT = 8'd3;
  localparam logic [31:0] NUM_METHODS_W  = NUM_METHODS;
  localparam logic [31:0] MAX_PARAMS_W   = MAX_PARAMS;

  state_t                    state_r, state_next_s;
  logic [7:0]                method_r, cid_r, np_r, status_r, tx_dat_r;
  logic [3:0]                nparams_r;
  logic [32*MAX_PARAMS-1:0]  params_r;
  logic [9:0]                cnt_r, total_s;
  logic [31:0]               retval_r;
  logic [2:0]                tx_idx_r, tx_idx_next_s;
  logic [15:0]               err_count_r;
  logic                      rx_ready_r, tx_valid_r, call_valid_r, rsp_ready_r;
  logic                      rx_fire_s, tx_fire_s, call_fire_s, rsp_fire_s;
  logic                      method_ok_s, too_many_s, cnt_last_s, timeout_s;

  function automatic logic [7:0] rsp_byte(input logic [2:0] idx, input logic [7:0] cid,
                                          input logic [7:0] status, input logic [31:0] retval);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_RSP;
      3'd1:    b = cid;
      3'd2:    b = status;
      3'd3:    b = retval[7:0];
      3'd4:    b = retval[15:8];
      3'd5:    b = retval[23:16];
      3'd6:    b = retval[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign rx_fire_s   = rx_valid && rx_ready_r;
  assign tx_fire_s   = tx_valid_r && tx_ready;
  assign call_fire_s = call_valid_r && call_ready;
  assign rsp_fire_s  = rsp_valid && rsp_ready_r;
  assign method_ok_s = ({24'd0, method_r} < NUM_METHODS_W);
  assign too_many_s  = ({24'd0, rx_dat} > MAX_PARAMS_W);
  assign total_s     = {np_r, 2'b00};
  assign cnt_last_s  = (cnt_r == total_s - 10'd1);

`ifdef TBLINK_RPC_RESP_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Cycles spent in CALL/WAIT_RSP; restarts from zero on every entry into CALL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_CALL || state_r == ST_WAIT_RSP) begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == ST_CALL || state_r == ST_WAIT_RSP) && (tmo_cnt_r == TMO_LAST);
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
  assign timeout_s    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state decode and response byte index.
  always_comb begin
    state_next_s  = state_r;
    tx_idx_next_s = 3'd0;
    case (state_r)
      ST_IDLE:    if (rx_fire_s && rx_dat == SYNC_REQ) state_next_s = ST_HDR_MID; else state_next_s = ST_IDLE;
      ST_HDR_MID: if (rx_fire_s) state_next_s = ST_HDR_CID; else state_next_s = ST_HDR_MID;
      ST_HDR_CID: if (rx_fire_s) state_next_s = ST_HDR_NP; else state_next_s = ST_HDR_CID;
      ST_HDR_NP: begin
        if (!rx_fire_s)             state_next_s = ST_HDR_NP;
        else if (too_many_s)        state_next_s = ST_DRAIN;
        else if (rx_dat != 8'd0)    state_next_s = ST_PARAMS;
        else if (method_ok_s)       state_next_s = ST_CALL;
        else                        state_next_s = ST_ERR_TX;
      end
      ST_PARAMS: begin
        if (rx_fire_s && cnt_last_s) state_next_s = method_ok_s ? ST_CALL : ST_ERR_TX;
        else                         state_next_s = ST_PARAMS;
      end
      ST_DRAIN:    if (rx_fire_s && cnt_last_s) state_next_s = ST_ERR_TX; else state_next_s = ST_DRAIN;
      ST_CALL: begin
        if (timeout_s)        state_next_s = ST_ERR_TX;
        else if (call_fire_s) state_next_s = ST_WAIT_RSP;
        else                  state_next_s = ST_CALL;
      end
      ST_WAIT_RSP: begin
        if (rsp_fire_s)     state_next_s = ST_TX;
        else if (timeout_s) state_next_s = ST_ERR_TX;
        else                state_next_s = ST_WAIT_RSP;
      end
      ST_ERR_TX:   state_next_s = ST_TX;
      ST_TX:       if (tx_fire_s && tx_idx_r == 3'd6) state_next_s = ST_IDLE; else state_next_s = ST_TX;
      default:     state_next_s = ST_IDLE;
    endcase
    if (state_next_s != ST_TX)                tx_idx_next_s = 3'd0;
    else if (state_r == ST_TX && tx_fire_s)   tx_idx_next_s = tx_idx_r + 3'd1;
    else                                      tx_idx_next_s = tx_idx_r;
  end

  // Request field capture, status/retval latching and error accounting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      method_r    <= 8'd0;
      cid_r       <= 8'd0;
      np_r        <= 8'd0;
      nparams_r   <= 4'd0;
      params_r    <= '0;
      cnt_r       <= 10'd0;
      status_r    <= 8'd0;
      retval_r    <= 32'd0;
      err_count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE:    if (rx_fire_s && rx_dat == SYNC_REQ) params_r <= '0;
        ST_HDR_MID: if (rx_fire_s) method_r <= rx_dat;
        ST_HDR_CID: if (rx_fire_s) cid_r <= rx_dat;
        ST_HDR_NP: if (rx_fire_s) begin
          np_r      <= rx_dat;
          nparams_r <= rx_dat[3:0];
          cnt_r     <= 10'd0;
          status_r  <= too_many_s ? STATUS_TOO_MANY : (method_ok_s ? STATUS_OK : STATUS_BAD_MID);
        end
        ST_PARAMS: if (rx_fire_s) begin
          for (int w = 0; w < MAX_PARAMS; w++) begin
            for (int b = 0; b < 4; b++) begin
              if (cnt_r == 10'(w * 4 + b)) params_r[w*32 + b*8 +: 8] <= rx_dat;
            end
          end
          cnt_r <= cnt_r + 10'd1;
        end
        ST_DRAIN: if (rx_fire_s) cnt_r <= cnt_r + 10'd1;
        ST_CALL:  if (timeout_s) status_r <= STATUS_TIMEOUT;
        ST_WAIT_RSP: begin
          if (rsp_fire_s) begin
            retval_r <= rsp_retval;
            status_r <= STATUS_OK;
          end else if (timeout_s) begin
            status_r <= STATUS_TIMEOUT;
          end
        end
        ST_ERR_TX: begin
          retval_r <= 32'd0;
          if (err_count_r != 16'hFFFF) err_count_r <= err_count_r + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered handshake outputs, derived from the upcoming state so they align with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready_r   <= 1'b0;
      call_valid_r <= 1'b0;
      rsp_ready_r  <= 1'b0;
      tx_valid_r   <= 1'b0;
      tx_dat_r     <= 8'd0;
      tx_idx_r     <= 3'd0;
    end else begin
      rx_ready_r   <= (state_next_s == ST_IDLE)   || (state_next_s == ST_HDR_MID) ||
                      (state_next_s == ST_HDR_CID) || (state_next_s == ST_HDR_NP) ||
                      (state_next_s == ST_PARAMS) || (state_next_s == ST_DRAIN);
      call_valid_r <= (state_next_s == ST_CALL);
      rsp_ready_r  <= (state_next_s == ST_WAIT_RSP);
      tx_valid_r   <= (state_next_s == ST_TX);
      tx_dat_r     <= (state_next_s == ST_TX) ? rsp_byte(tx_idx_next_s, cid_r, status_r, retval_r) : 8'd0;
      tx_idx_r     <= tx_idx_next_s;
    end
  end

  assign rx_ready     = rx_ready_r;
  assign tx_dat       = tx_dat_r;
  assign tx_valid     = tx_valid_r;
  assign call_valid   = call_valid_r;
  assign call_method  = method_r;
  assign call_id      = cid_r;
  assign call_nparams = nparams_r;
  assign call_params  = params_r;
  assign rsp_ready    = rsp_ready_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_tblink_rpc_invoke_responder.sv
// Directed bench for tblink_rpc_invoke_responder; timeout scenario runs when TBLINK_RPC_RESP_TIMEOUT_EN is defined.
module tb_tblink_rpc_invoke_responder;
  localparam int MAXP = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_dat = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_dat;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              call_valid;
  logic              call_ready = 1'b0;
  logic [7:0]        call_method;
  logic [7:0]        call_id;
  logic [3:0]        call_nparams;
  logic [32*MAXP-1:0] call_params;
  logic              rsp_valid = 1'b0;
  logic              rsp_ready;
  logic [31:0]       rsp_retval = 32'h0;
  logic [15:0]       err_count;

  int checks = 0;
  int errors = 0;
  logic [55:0] got;

  always #5 clock = ~clock;

  tblink_rpc_invoke_responder #(.NUM_METHODS(16), .MAX_PARAMS(MAXP), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .call_valid(call_valid), .call_ready(call_ready), .call_method(call_method),
    .call_id(call_id), .call_nparams(call_nparams), .call_params(call_params),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_retval(rsp_retval),
    .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    rx_dat   = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin @(negedge clock); n++; end
    chk("rx_ready_wait", rx_ready, 1'b1);
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] mid, input logic [7:0] cid, input logic [7:0] np);
    send_byte(8'hA5); send_byte(mid); send_byte(cid); send_byte(np);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
  endtask

  task automatic accept_call();
    @(negedge clock);
    chk("call_valid_pending", call_valid, 1'b1);
    call_ready = 1'b1;
    @(posedge clock); #1;
    call_ready = 1'b0;
    chk("call_valid_drop", call_valid, 1'b0);
  endtask

  task automatic respond(input logic [31:0] v);
    @(negedge clock);
    chk("rsp_ready_wait", rsp_ready, 1'b1);
    rsp_valid  = 1'b1;
    rsp_retval = v;
    @(posedge clock); #1;
    rsp_valid = 1'b0;
    chk("tx_valid_next", tx_valid, 1'b1);
  endtask

  task automatic recv_rsp(input bit stall, output logic [55:0] r);
    logic [7:0] held;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      int n = 0;
      @(negedge clock);
      while (!tx_valid && n < 100) begin @(negedge clock); n++; end
      chk("tx_valid_wait", tx_valid, 1'b1);
      if (stall) begin
        tx_ready = 1'b0;
        held = tx_dat;
        @(negedge clock);
        chk("tx_dat_hold", tx_dat, held);
        chk("tx_valid_hold", tx_valid, 1'b1);
      end
      tx_ready = 1'b1;
      r = {r[47:0], tx_dat};
      @(posedge clock); #1;
      tx_ready = 1'b0;
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_dat", tx_dat, 8'h00);
    chk("rst_call_valid", call_valid, 1'b0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_err_count", err_count, 16'd0);
    chk("rst_params", call_params, 128'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rx_ready_after_rst", rx_ready, 1'b1);

    // Frame with two params, normal response
    send_hdr(8'h03, 8'h11, 8'h02);
    send_word(32'h12345678);
    send_word(32'hCAFEBABE);
    chk("a_call_valid", call_valid, 1'b1);
    chk("a_rx_ready_low", rx_ready, 1'b0);
    chk("a_method", call_method, 8'h03);
    chk("a_id", call_id, 8'h11);
    chk("a_nparams", call_nparams, 4'd2);
    chk("a_params", call_params, {32'h0, 32'h0, 32'hCAFEBABE, 32'h12345678});
    @(negedge clock);
    rsp_valid = 1'b1; rsp_retval = 32'h11111111;
    @(posedge clock); #1;
    rsp_valid = 1'b0;
    chk("a_early_rsp_ignored", tx_valid, 1'b0);
    accept_call();
    respond(32'hDEADBEEF);
    recv_rsp(1'b0, got);
    chk("a_tx_frame", got, 56'h5A1100EFBEADDE);
    chk("a_rx_ready_back", rx_ready, 1'b1);

    // Invalid method id
    send_hdr(8'h14, 8'h22, 8'h00);
    chk("b_no_call", call_valid, 1'b0);
    recv_rsp(1'b0, got);
    chk("b_tx_frame", got, 56'h5A220100000000);
    chk("b_err_count", err_count, 16'd1);

    // Too many params: 24 bytes drained
    send_hdr(8'h01, 8'h33, 8'h06);
    for (int i = 0; i < 24; i++) send_byte(8'(i + 16));
    chk("c_no_call", call_valid, 1'b0);
    recv_rsp(1'b0, got);
    chk("c_tx_frame", got, 56'h5A330200000000);
    chk("c_err_count", err_count, 16'd2);

    // Garbage before sync, zero params, stalled response
    send_byte(8'h00);
    send_byte(8'hFF);
    send_hdr(8'h02, 8'h44, 8'h00);
    chk("d_call_valid", call_valid, 1'b1);
    chk("d_method", call_method, 8'h02);
    chk("d_id", call_id, 8'h44);
    chk("d_nparams", call_nparams, 4'd0);
    chk("d_params_cleared", call_params, 128'd0);
    accept_call();
    respond(32'h01020304);
    recv_rsp(1'b1, got);
    chk("d_tx_frame", got, 56'h5A440004030201);
    chk("d_err_count", err_count, 16'd2);

    // Reset during parameter bytes
    send_hdr(8'h05, 8'h55, 8'h03);
    send_byte(8'h99);
    send_byte(8'h88);
    reset_n = 1'b0;
    #1;
    chk("e_rst_rx_ready", rx_ready, 1'b0);
    chk("e_rst_method", call_method, 8'h00);
    chk("e_rst_params", call_params, 128'd0);
    chk("e_rst_err_count", err_count, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("e_rx_ready_release", rx_ready, 1'b1);
    chk("e_no_partial_tx", tx_valid, 1'b0);
    send_hdr(8'h07, 8'h66, 8'h01);
    send_word(32'hAABBCCDD);
    chk("e_method", call_method, 8'h07);
    chk("e_nparams", call_nparams, 4'd1);
    chk("e_params", call_params, {96'h0, 32'hAABBCCDD});
    accept_call();
    respond(32'h00000080);
    recv_rsp(1'b0, got);
    chk("e_tx_frame", got, 56'h5A660080000000);

`ifdef TBLINK_RPC_RESP_TIMEOUT_EN
    // No response from user logic: timeout response, late rsp ignored
    send_hdr(8'h04, 8'h77, 8'h00);
    chk("f_call_valid", call_valid, 1'b1);
    recv_rsp(1'b0, got);
    chk("f_tx_frame", got, 56'h5A770300000000);
    chk("f_err_count", err_count, 16'd1);
    chk("f_call_dropped", call_valid, 1'b0);
    @(negedge clock);
    rsp_valid = 1'b1; rsp_retval = 32'h55AA55AA;
    repeat (3) @(negedge clock);
    chk("f_rsp_ready_low", rsp_ready, 1'b0);
    chk("f_late_rsp_no_tx", tx_valid, 1'b0);
    rsp_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
